// File: rtl/mdu_hazard_ctrl_pkg.sv
// Shared definitions for the MDU hazard controller: op codes, FSM states, HI/LO mask bits.
package mdu_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_NONE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_MT   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    localparam int HILO_LO = 0;
    localparam int HILO_HI = 1;

    function automatic int max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_hazard_ctrl_if.sv
// Issue / D-stage read / result-bus signals between the pipeline and the MDU hazard controller.
interface mdu_hazard_ctrl_if;
    logic       issue_valid;
    logic [1:0] issue_op;
    logic [1:0] issue_hilo_w;
    logic       flush;
    logic [1:0] d_hilo_r;
    logic       res_valid;
    logic [1:0] res_hilo_w;
    logic       busy;
    logic       issue_stall;
    logic       read_stall;
    logic       fwd_lo;
    logic       fwd_hi;

    modport master (
        output issue_valid, issue_op, issue_hilo_w, flush, d_hilo_r,
        input  res_valid, res_hilo_w, busy, issue_stall, read_stall, fwd_lo, fwd_hi
    );

    modport slave (
        input  issue_valid, issue_op, issue_hilo_w, flush, d_hilo_r,
        output res_valid, res_hilo_w, busy, issue_stall, read_stall, fwd_lo, fwd_hi
    );
endinterface

// File: rtl/mdu_hazard_ctrl_lat_counter.sv
// Loadable down counter that times the RUN phase of a multi-cycle MDU op.
module mdu_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)    cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec)  cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mdu_hazard_ctrl.sv
// Tracks the single in-flight mul/div, stalls dependent HI/LO reads and issues, and forwards the result.
module mdu_hazard_ctrl
    import mdu_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    mdu_hazard_ctrl_if.slave  bus
);
    if (MUL_LAT < 1 || MUL_LAT > 63 || DIV_LAT < 1 || DIV_LAT > 63) begin : g_bad_lat
        $error("mdu_hazard_ctrl: MUL_LAT/DIV_LAT must be in 1..63");
    end
    if ((max_lat(MUL_LAT, DIV_LAT) - 1) >= (1 << CNT_W)) begin : g_bad_cnt
        $error("mdu_hazard_ctrl: CNT_W too narrow for the configured latencies");
    end

    // Counter preload is LAT-2: the load cycle and the final cnt==0 RUN cycle both count.
    localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 2);
    localparam bit               MUL_ONE = (MUL_LAT == 1);
    localparam bit               DIV_ONE = (DIV_LAT == 1);

    mdu_state_e       state, state_n;
    logic [1:0]       pending, pending_n;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             is_md, is_mul, in_run, in_done;

    assign is_mul  = (bus.issue_op == MDU_MUL);
    assign is_md   = bus.issue_valid && (is_mul || bus.issue_op == MDU_DIV);
    assign in_run  = (state == ST_RUN);
    assign in_done = (state == ST_DONE);

    mdu_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pending <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n    = state;
        pending_n  = pending;
        cnt_load   = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;
        if (in_run) begin
            if (cnt_zero) state_n = ST_DONE;
            else          cnt_dec = 1'b1;
        end else begin
            if (in_done) begin
                state_n   = ST_IDLE;
                pending_n = '0;
            end
            // mt is accepted here too but leaves state and pending alone.
            if (is_md) begin
                pending_n = bus.issue_hilo_w;
                if (is_mul ? MUL_ONE : DIV_ONE) begin
                    state_n = ST_DONE;
                end else begin
                    state_n    = ST_RUN;
                    cnt_load   = 1'b1;
                    cnt_ld_val = is_mul ? MUL_LD : DIV_LD;
                end
            end
        end
        if (bus.flush) begin
            state_n    = ST_IDLE;
            pending_n  = '0;
            cnt_load   = 1'b1;
            cnt_ld_val = '0;
            cnt_dec    = 1'b0;
        end
    end

    // Outputs are forced low while reset is held, even if state still shows an old op.
    assign bus.busy        = reset && (state != ST_IDLE);
    assign bus.res_valid   = reset && in_done && !bus.flush;
    assign bus.res_hilo_w  = bus.res_valid ? pending : 2'b00;
    assign bus.issue_stall = reset && bus.issue_valid && (bus.issue_op != MDU_NONE) && in_run;
    assign bus.read_stall  = reset && in_run && ((bus.d_hilo_r & pending) != 2'b00);
    assign bus.fwd_lo      = bus.res_valid && bus.d_hilo_r[HILO_LO] && pending[HILO_LO];
    assign bus.fwd_hi      = bus.res_valid && bus.d_hilo_r[HILO_HI] && pending[HILO_HI];
endmodule

// File: tb/tb_mdu_hazard_ctrl.sv
// Two controller configurations driven by one stimulus stream and checked against a cycle-stamp model.
module tb_mdu_hazard_ctrl;
    import mdu_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       iv = 1'b0, fl = 1'b0;
    logic [1:0] op = 2'b00, hw = 2'b00, dr = 2'b00;

    mdu_hazard_ctrl_if ifa ();
    mdu_hazard_ctrl_if ifb ();

    assign ifa.issue_valid = iv;  assign ifb.issue_valid = iv;
    assign ifa.issue_op = op;     assign ifb.issue_op = op;
    assign ifa.issue_hilo_w = hw; assign ifb.issue_hilo_w = hw;
    assign ifa.flush = fl;        assign ifb.flush = fl;
    assign ifa.d_hilo_r = dr;     assign ifb.d_hilo_r = dr;

    mdu_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(6)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mdu_hazard_ctrl #(.MUL_LAT(1), .DIV_LAT(5),  .CNT_W(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted mul/div at cycle t has its result on the bus at cycle t+LAT; stall before that.
    int         t = 0;
    bit         m_act [2];
    int         m_rc  [2];
    logic [1:0] m_pend[2];
    int         m_lmul[2] = '{3, 1};
    int         m_ldiv[2] = '{33, 5};

    always @(posedge clk) begin : model_upd
        bit run;
        for (int i = 0; i < 2; i++) begin
            run = m_act[i] && (t < m_rc[i]);
            if (!reset || fl) begin
                m_act[i] = 1'b0;
                m_pend[i] = 2'b00;
            end else if (!run) begin
                if (m_act[i]) begin
                    m_act[i] = 1'b0;
                    m_pend[i] = 2'b00;
                end
                if (iv && (op == 2'b01 || op == 2'b10)) begin
                    m_act[i] = 1'b1;
                    m_rc[i] = t + ((op == 2'b01) ? m_lmul[i] : m_ldiv[i]);
                    m_pend[i] = hw;
                end
            end
        end
        t++;
    end

    task automatic cmp_inst(input int i, input string p, input logic [7:0] o);
        bit run, done, rv;
        run  = m_act[i] && (t < m_rc[i]);
        done = m_act[i] && (t == m_rc[i]);
        rv   = reset && done && !fl;
        chk({p, "_busy"},        {3'b0, o[7]}, {3'b0, reset && (run || done)});
        chk({p, "_res_valid"},   {3'b0, o[6]}, {3'b0, rv});
        chk({p, "_issue_stall"}, {3'b0, o[5]}, {3'b0, reset && iv && (op != 2'b00) && run});
        chk({p, "_read_stall"},  {3'b0, o[4]}, {3'b0, reset && run && ((dr & m_pend[i]) != 2'b00)});
        chk({p, "_fwd_lo"},      {3'b0, o[3]}, {3'b0, rv && dr[0] && m_pend[i][0]});
        chk({p, "_fwd_hi"},      {3'b0, o[2]}, {3'b0, rv && dr[1] && m_pend[i][1]});
        if (rv) chk({p, "_res_hilo_w"}, {2'b0, o[1:0]}, {2'b0, m_pend[i]});
    endtask

    always @(negedge clk) begin
        cmp_inst(0, "A", {ifa.busy, ifa.res_valid, ifa.issue_stall, ifa.read_stall,
                          ifa.fwd_lo, ifa.fwd_hi, ifa.res_hilo_w});
        cmp_inst(1, "B", {ifb.busy, ifb.res_valid, ifb.issue_stall, ifb.read_stall,
                          ifb.fwd_lo, ifb.fwd_hi, ifb.res_hilo_w});
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] o, input logic [1:0] h,
                       input logic f, input logic [1:0] d);
        iv = v; op = o; hw = h; fl = f; dr = d;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            nxt();
            drv(1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
        end
    endtask

    task automatic zero_a(input string nm);
        chk(nm, {ifa.busy, ifa.res_valid, ifa.issue_stall, ifa.read_stall}, 4'h0);
        chk(nm, {ifa.fwd_lo, ifa.fwd_hi, ifa.res_hilo_w}, 4'h0);
    endtask

    initial begin
        drv(1'b1, 2'b10, 2'b11, 1'b0, 2'b11);
        repeat (2) nxt();
        zero_a("reset_outputs");
        reset = 1'b1;
        drv(1'b0, 2'b00, 2'b00, 1'b0, 2'b11);
        zero_a("post_reset_outputs");

        // Div, mask 11, HI read every cycle.
        idle(3);
        for (int c = 0; c <= 35; c++) begin
            nxt();
            drv(c == 0, 2'b10, 2'b11, 1'b0, 2'b10);
            chk("div_busy",   {3'b0, ifa.busy},       {3'b0, c >= 1 && c <= 33});
            chk("div_res",    {3'b0, ifa.res_valid},  {3'b0, c == 33});
            chk("div_rstall", {3'b0, ifa.read_stall}, {3'b0, c >= 1 && c <= 32});
            chk("div_fwd_hi", {3'b0, ifa.fwd_hi},     {3'b0, c == 33});
        end

        // Mul, mask 01: HI read never stalls, LO read stalls then forwards.
        for (int pass = 0; pass < 2; pass++) begin
            idle(40);
            for (int c = 0; c <= 5; c++) begin
                nxt();
                drv(c == 0, 2'b01, 2'b01, 1'b0, (pass == 0) ? 2'b10 : 2'b01);
                chk("mul_res", {3'b0, ifa.res_valid}, {3'b0, c == 3});
                chk("mul_rstall", {3'b0, ifa.read_stall}, {3'b0, pass == 1 && (c == 1 || c == 2)});
                chk("mul_fwd_lo", {3'b0, ifa.fwd_lo}, {3'b0, pass == 1 && c == 3});
            end
        end

        // Empty write mask still pulses the result.
        idle(40);
        for (int c = 0; c <= 4; c++) begin
            nxt();
            drv(c == 0, 2'b01, 2'b00, 1'b0, 2'b11);
            chk("mask0_res", {3'b0, ifa.res_valid}, {3'b0, c == 3});
            if (c == 3) chk("mask0_w", {2'b0, ifa.res_hilo_w}, 4'h0);
            chk("mask0_rstall", {3'b0, ifa.read_stall}, 4'h0);
        end

        // Flush at cycle 5 of a div, mt at cycle 6.
        idle(40);
        for (int c = 0; c <= 40; c++) begin
            nxt();
            if (c == 6) drv(1'b1, 2'b11, 2'b01, 1'b0, 2'b00);
            else        drv(c == 0, 2'b10, 2'b11, c == 5, 2'b00);
            chk("flush_res", {3'b0, ifa.res_valid}, 4'h0);
            if (c == 6) begin
                chk("flush_idle", {3'b0, ifa.busy}, 4'h0);
                chk("flush_mt_stall", {3'b0, ifa.issue_stall}, 4'h0);
            end
        end

        // Mul issued in the div's DONE cycle.
        idle(40);
        for (int c = 0; c <= 38; c++) begin
            nxt();
            drv(c == 0 || c == 33, (c == 33) ? 2'b01 : 2'b10, 2'b11, 1'b0, 2'b00);
            chk("b2b_res", {3'b0, ifa.res_valid}, {3'b0, c == 33 || c == 36});
            chk("b2b_istall", {3'b0, ifa.issue_stall}, 4'h0);
        end

        // Single-cycle mul on the second instance.
        idle(40);
        for (int c = 0; c <= 3; c++) begin
            nxt();
            drv(c == 0, 2'b01, 2'b01, 1'b0, 2'b01);
            chk("lat1_res",    {3'b0, ifb.res_valid},  {3'b0, c == 1});
            chk("lat1_busy",   {3'b0, ifb.busy},       {3'b0, c == 1});
            chk("lat1_rstall", {3'b0, ifb.read_stall}, 4'h0);
        end

        // Reset pulse mid-RUN, then a fresh mul.
        idle(40);
        for (int c = 0; c <= 12; c++) begin
            nxt();
            reset = (c != 5);
            drv(c == 0 || c == 7, (c == 7) ? 2'b01 : 2'b10, 2'b11, 1'b0, 2'b11);
            if (c == 5 || c == 6) zero_a("midrun_reset");
            if (c >= 6) chk("rst_then_mul", {3'b0, ifa.res_valid}, {3'b0, c == 10});
        end

        // Random traffic, model checks every cycle.
        idle(40);
        repeat (3000) begin
            nxt();
            reset = ($urandom_range(0, 199) != 0);
            drv($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)));
        end
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
